// File: rtl/rl_strobe_sequencer_if.sv
// Read/load arbitration handshake between acquisition control, the strobe
// sequencer and the read/load arbiter.
interface rl_strobe_sequencer_if;
  logic en;
  logic load_req;
  logic R_L_state;
  logic R_L_con;
  logic fdata_G;
  logic LOAD_G;
  logic READ_G;
  logic busy;
  logic load_ack;
  logic frame_done;
  logic granted_load;

  modport master (
    input  en, load_req, R_L_state,
    output R_L_con, fdata_G, LOAD_G, READ_G, busy, load_ack, frame_done, granted_load
  );

  modport slave (
    output en, load_req, R_L_state,
    input  R_L_con, fdata_G, LOAD_G, READ_G, busy, load_ack, frame_done, granted_load
  );
endinterface

// File: rtl/rl_strobe_sequencer.sv
// Frame sequencer: presents a mode request, strobes the frame, samples the
// arbiter grant and issues exactly one LOAD or READ burst per frame.
module rl_strobe_sequencer #(
  parameter int SETTLE_CYC = 3,
  parameter int PULSE_HI   = 2,
  parameter int PULSE_LO   = 2,
  parameter int N_LOAD     = 7,
  parameter int N_READ     = 4,
  parameter int GAP_CYC    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  rl_strobe_sequencer_if.master   bus
);

  localparam int NMAX = (N_LOAD > N_READ) ? N_LOAD : N_READ;
  localparam int PW   = $clog2(NMAX + 1);
  localparam int CM0  = (SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC;
  localparam int CM1  = (PULSE_HI > PULSE_LO) ? PULSE_HI : PULSE_LO;
  localparam int CMAX = (CM0 > CM1) ? CM0 : CM1;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, SETUP, FSTB, SETTLE, PHI, PLO, GAP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pulse_q, pulse_d;
  logic          rl_con_q, rl_con_d;
  logic          fdata_q, fdata_d;
  logic          load_q, load_d;
  logic          read_q, read_d;
  logic          busy_q, busy_d;
  logic          ack_q, ack_d;
  logic          done_q, done_d;
  logic          granted_q, granted_d;
  logic          grant_sel;
  logic [PW-1:0] last_pulse;

  assign last_pulse = granted_q ? PW'(N_LOAD - 1) : PW'(N_READ - 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    unique case (state_q)
      IDLE:   if (bus.en) state_d = SETUP;
      SETUP:  state_d = FSTB;
      FSTB: begin
        state_d = SETTLE;
        cnt_d   = '0;
      end
      SETTLE: begin
        if (cnt_q == CW'(SETTLE_CYC - 1)) begin
          state_d = PHI;
          cnt_d   = '0;
          pulse_d = '0;
        end else cnt_d = cnt_q + CW'(1);
      end
      PHI: begin
        if (cnt_q == CW'(PULSE_HI - 1)) begin
          state_d = PLO;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
      end
      PLO: begin
        if (cnt_q == CW'(PULSE_LO - 1)) begin
          cnt_d = '0;
          if (pulse_q == last_pulse) state_d = GAP;
          else begin
            state_d = PHI;
            pulse_d = pulse_q + PW'(1);
          end
        end else cnt_d = cnt_q + CW'(1);
      end
      GAP: begin
        if (cnt_q == CW'(GAP_CYC - 1)) begin
          state_d = bus.en ? SETUP : IDLE;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pulse_d = '0;
      end
    endcase
  end

  // Outputs are registered off the next state, so they line up with the state
  // they belong to; the first PHI cycle must see the grant as it is sampled.
  always_comb begin
    grant_sel = (state_q == SETTLE) ? bus.R_L_state : granted_q;
    granted_d = granted_q;
    if (state_q == SETTLE && cnt_q == CW'(SETTLE_CYC - 1)) granted_d = bus.R_L_state;
    rl_con_d  = (state_d == SETUP) ? bus.load_req : rl_con_q;
    fdata_d   = (state_d == FSTB);
    load_d    = (state_d == PHI) &&  grant_sel;
    read_d    = (state_d == PHI) && !grant_sel;
    busy_d    = (state_d != IDLE);
    ack_d     = (state_q == PLO) && (state_d == GAP) && granted_q;
    done_d    = (state_d == GAP) && (cnt_d == CW'(GAP_CYC - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pulse_q   <= '0;
      rl_con_q  <= 1'b0;
      fdata_q   <= 1'b0;
      load_q    <= 1'b0;
      read_q    <= 1'b0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
      granted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
      rl_con_q  <= rl_con_d;
      fdata_q   <= fdata_d;
      load_q    <= load_d;
      read_q    <= read_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      granted_q <= granted_d;
    end
  end

  assign bus.R_L_con      = rl_con_q;
  assign bus.fdata_G      = fdata_q;
  assign bus.LOAD_G       = load_q;
  assign bus.READ_G       = read_q;
  assign bus.busy         = busy_q;
  assign bus.load_ack     = ack_q;
  assign bus.frame_done   = done_q;
  assign bus.granted_load = granted_q;

endmodule

// File: tb/tb_rl_strobe_sequencer.sv
// Scoreboard bench: each test pushes its expected frame summary and compares
// it with what the monitor collected when frame_done appears.
module tb_rl_strobe_sequencer;
  localparam int PULSE_HI = 2;
  localparam int PULSE_LO = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  rl_strobe_sequencer_if bus();
  rl_strobe_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct packed {
    int   nload;
    int   nread;
    int   nack;
    int   len;
    logic granted;
    int   badw;
    logic rlcon;
  } frame_t;

  frame_t exp_q[$];
  int checks = 0;
  int failures = 0;

  int   cyc = 0, nload = 0, nread = 0, nack = 0, badw = 0;
  int   hirun = 0, lorun = 0, fdata_total = 0, excl_err = 0, rlcon_err = 0;
  logic obs_rlcon = 1'b0, seen_pulse = 1'b0, prev_load = 1'b0, prev_read = 1'b0;
  logic prev_rlcon = 1'b0, chg_prev = 1'b0;

  function automatic frame_t model(input logic g, input logic rc);
    frame_t f;
    int n;
    n = g ? 7 : 4;
    f.nload   = g ? 7 : 0;
    f.nread   = g ? 0 : 4;
    f.nack    = g ? 1 : 0;
    f.len     = 2 + 3 + n * (PULSE_HI + PULSE_LO) + 2;
    f.granted = g;
    f.badw    = 0;
    f.rlcon   = rc;
    return f;
  endfunction

  function automatic frame_t observed();
    frame_t f;
    f.nload   = nload;
    f.nread   = nread;
    f.nack    = nack;
    f.len     = cyc + 2;
    f.granted = bus.granted_load;
    f.badw    = badw;
    f.rlcon   = obs_rlcon;
    return f;
  endfunction

  function automatic string fmt(input frame_t f);
    return $sformatf("nload=%0d nread=%0d ack=%0d len=%0d gl=%0d badw=%0d rlcon=%0d",
                     f.nload, f.nread, f.nack, f.len, f.granted, f.badw, f.rlcon);
  endfunction

  // Frame monitor: cycle counts are relative to the fdata_G cycle.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      hirun = 0; lorun = 0; seen_pulse = 0; chg_prev = 0;
      prev_rlcon = 0; prev_load = 0; prev_read = 0;
    end else begin
      if (bus.LOAD_G && bus.READ_G) excl_err++;
      if (chg_prev && !bus.fdata_G) rlcon_err++;
      chg_prev   = (bus.R_L_con !== prev_rlcon);
      prev_rlcon = bus.R_L_con;
      if (bus.fdata_G) begin
        fdata_total++;
        cyc = 0; nload = 0; nread = 0; nack = 0; badw = 0; seen_pulse = 0;
        obs_rlcon = bus.R_L_con;
      end else cyc++;
      if (bus.LOAD_G && !prev_load) nload++;
      if (bus.READ_G && !prev_read) nread++;
      if (bus.LOAD_G || bus.READ_G) begin
        if (hirun == 0 && seen_pulse && lorun != PULSE_LO) badw++;
        hirun++; lorun = 0; seen_pulse = 1;
      end else begin
        if (hirun != 0 && hirun != PULSE_HI) badw++;
        hirun = 0; lorun++;
      end
      if (bus.load_ack) nack++;
      prev_load = bus.LOAD_G;
      prev_read = bus.READ_G;
    end
  end

  // sel: 0 fdata_G, 1 frame_done, 2 third LOAD_G pulse high, 3 any LOAD_G high
  task automatic wait_for(input int sel, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if ((sel == 0 && bus.fdata_G) || (sel == 1 && bus.frame_done) ||
          (sel == 2 && bus.LOAD_G && nload == 3) || (sel == 3 && bus.LOAD_G)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.R_L_con, bus.fdata_G, bus.LOAD_G, bus.READ_G, bus.busy, bus.load_ack,
         bus.frame_done, bus.granted_load} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs: got %b, want 00000000",
               {bus.R_L_con, bus.fdata_G, bus.LOAD_G, bus.READ_G, bus.busy, bus.load_ack,
                bus.frame_done, bus.granted_load});
    end
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.fdata_G !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold: busy=%b fdata=%b, want 0 0", bus.busy, bus.fdata_G);
    end
  endtask

  // One frame with en dropped after the strobe; grant_late raises R_L_state mid-SETTLE.
  task automatic run_frame(input string name, input logic lr, input logic rs,
                           input logic grant_late, input logic exp_g);
    bit ok;
    frame_t f, o;
    bus.load_req = lr;
    bus.R_L_state = rs;
    bus.en = 1'b1;
    exp_q.push_back(model(exp_g, lr));
    wait_for(0, ok);
    bus.en = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_fdata: no fdata_G within 100 cycles, want one", name);
    end
    if (grant_late) begin
      repeat (2) @(negedge clk);
      #1 bus.R_L_state = 1'b1;
    end
    wait_for(1, ok);
    f = exp_q.pop_front();
    o = observed();
    checks++;
    if (!ok || o !== f) begin
      failures++;
      $display("FAIL %s_frame: got %s done=%0d, want %s", name, fmt(o), ok, fmt(f));
    end
    repeat (3) @(negedge clk);
    #1 bus.R_L_state = 1'b0;
  endtask

  task automatic test_read_frame();
    run_frame("read", 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_load_frame();
    run_frame("load", 1'b1, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_grant_mismatch();
    run_frame("mismatch", 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_en_drop();
    bit ok;
    int ft;
    frame_t f, o;
    bus.load_req = 1'b1;
    bus.R_L_state = 1'b1;
    bus.en = 1'b1;
    exp_q.push_back(model(1'b1, 1'b1));
    wait_for(2, ok);
    bus.en = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL en_drop_pulse3: third LOAD_G pulse not seen, want it");
    end
    wait_for(1, ok);
    f = exp_q.pop_front();
    o = observed();
    checks++;
    if (!ok || o !== f) begin
      failures++;
      $display("FAIL en_drop_frame: got %s done=%0d, want %s", fmt(o), ok, fmt(f));
    end
    ft = fdata_total;
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || fdata_total != ft) begin
      failures++;
      $display("FAIL en_drop_idle: busy=%b extra_fdata=%0d, want 0 0", bus.busy, fdata_total - ft);
    end
    bus.R_L_state = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    frame_t f, o;
    bus.load_req = 1'b1;
    bus.R_L_state = 1'b1;
    bus.en = 1'b1;
    wait_for(3, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rst_mid_load: LOAD_G never high, want high");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.R_L_con, bus.fdata_G, bus.LOAD_G, bus.READ_G, bus.busy, bus.load_ack,
         bus.frame_done, bus.granted_load} !== 8'h00) begin
      failures++;
      $display("FAIL rst_mid_outputs: got %b, want 00000000 before next edge",
               {bus.R_L_con, bus.fdata_G, bus.LOAD_G, bus.READ_G, bus.busy, bus.load_ack,
                bus.frame_done, bus.granted_load});
    end
    bus.load_req = 1'b0;
    bus.R_L_state = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.fdata_G !== 1'b0) begin
      failures++;
      $display("FAIL rst_restart_setup: busy=%b fdata=%b, want 1 0", bus.busy, bus.fdata_G);
    end
    exp_q.push_back(model(1'b0, 1'b0));
    @(negedge clk);
    #1;
    bus.en = 1'b0;
    checks++;
    if (bus.fdata_G !== 1'b1) begin
      failures++;
      $display("FAIL rst_restart_fstb: fdata=%b, want 1", bus.fdata_G);
    end
    wait_for(1, ok);
    f = exp_q.pop_front();
    o = observed();
    checks++;
    if (!ok || o !== f) begin
      failures++;
      $display("FAIL rst_restart_frame: got %s done=%0d, want %s", fmt(o), ok, fmt(f));
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic lr;
    frame_t f, o;
    lr = 1'b1;
    bus.load_req = lr;
    bus.R_L_state = lr;
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(model(lr, lr));
      wait_for(1, ok);
      f = exp_q.pop_front();
      o = observed();
      checks++;
      if (!ok || o !== f) begin
        failures++;
        $display("FAIL b2b_frame%0d: got %s done=%0d, want %s", i, fmt(o), ok, fmt(f));
      end
      lr = ~lr;
      bus.load_req = lr;
      bus.R_L_state = lr;
      if (i == 3) bus.en = 1'b0;
    end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (excl_err != 0) begin
      failures++;
      $display("FAIL mutex: LOAD_G&READ_G high in %0d cycles, want 0", excl_err);
    end
    checks++;
    if (rlcon_err != 0) begin
      failures++;
      $display("FAIL rlcon_stable: R_L_con changed outside SETUP %0d times, want 0", rlcon_err);
    end
  endtask

  initial begin
    bus.en = 1'b0;
    bus.load_req = 1'b0;
    bus.R_L_state = 1'b0;
    test_reset();
    test_read_frame();
    test_load_frame();
    test_grant_mismatch();
    test_en_drop();
    test_reset_mid_burst();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
